// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection.
//
// Captures the decoded operands, register addresses and control bits from
// decode and presents them to execute. A load in EX whose destination feeds
// the instruction in ID causes a one-cycle bubble. An external stall holds
// the stage, and a branch flush clears it.
//
// Optional feature macro: ID_EX_HAZARD_DETECT_EN
//   defined   : load-use detection is active, hazard_stall and bubble_cnt are live
//   undefined : no internal detection, hazard_stall = 0 and bubble_cnt = 0;
//               hazards must be resolved externally through stall_ext/flush
module id_ex_stage_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     pc_ID,
    input  logic [DATA_WIDTH-1:0]     readData1_ID,
    input  logic [DATA_WIDTH-1:0]     readData2_ID,
    input  logic [DATA_WIDTH-1:0]     imm_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
    input  logic                      regWrite_ID,
    input  logic                      memRead_ID,
    input  logic                      memWrite_ID,
    input  logic                      memToReg_ID,
    input  logic                      aluSrc_ID,
    input  logic [ALUOP_WIDTH-1:0]    aluOp_ID,
    input  logic                      valid_ID,
    input  logic                      stall_ext,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     pc_IDEX,
    output logic [DATA_WIDTH-1:0]     readData1_IDEX,
    output logic [DATA_WIDTH-1:0]     readData2_IDEX,
    output logic [DATA_WIDTH-1:0]     imm_IDEX,
    output logic [REG_ADDR_WIDTH-1:0] rs1_IDEX,
    output logic [REG_ADDR_WIDTH-1:0] rs2_IDEX,
    output logic [REG_ADDR_WIDTH-1:0] rd_IDEX,
    output logic                      regWrite_IDEX,
    output logic                      memRead_IDEX,
    output logic                      memWrite_IDEX,
    output logic                      memToReg_IDEX,
    output logic                      aluSrc_IDEX,
    output logic [ALUOP_WIDTH-1:0]    aluOp_IDEX,
    output logic                      valid_IDEX,
    output logic                      hazard_stall,
    output logic [CNT_WIDTH-1:0]      bubble_cnt
);

    // All stage fields are carried as one flat vector so that flush, hold,
    // bubble and load treat every field identically.
    localparam int STAGE_W = 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH + 5 + ALUOP_WIDTH + 1;

    localparam logic [STAGE_W-1:0]        STAGE_ZERO = {STAGE_W{1'b0}};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO   = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic [STAGE_W-1:0]   w_id_stage;
    logic [STAGE_W-1:0]   r_stage;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic                 w_hazard;
    logic                 w_bubble_ins;

    assign w_id_stage = {valid_ID, aluOp_ID, aluSrc_ID, memToReg_ID, memWrite_ID,
                         memRead_ID, regWrite_ID, rd_ID, rs2_ID, rs1_ID,
                         imm_ID, readData2_ID, readData1_ID, pc_ID};

    assign {valid_IDEX, aluOp_IDEX, aluSrc_IDEX, memToReg_IDEX, memWrite_IDEX,
            memRead_IDEX, regWrite_IDEX, rd_IDEX, rs2_IDEX, rs1_IDEX,
            imm_IDEX, readData2_IDEX, readData1_IDEX, pc_IDEX} = r_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
    // Load-use detection: a valid load in EX writing a nonzero register that
    // either source of the valid ID instruction reads. Both sources are
    // compared regardless of whether the instruction actually uses them.
    always_comb begin
        w_hazard = valid_IDEX & memRead_IDEX & (rd_IDEX != REG_ZERO) & valid_ID &
                   ((rd_IDEX == rs1_ID) | (rd_IDEX == rs2_ID));
    end
`else
    // Detection disabled: the stage never generates its own bubbles.
    always_comb begin
        w_hazard = 1'b0;
    end
`endif

    // A redirect makes the dependent instruction irrelevant, so flush masks
    // the stall request; an external stall does not.
    always_comb begin
        hazard_stall = w_hazard & ~flush;
        w_bubble_ins = w_hazard & ~flush & ~stall_ext;
    end

    // Stage register: flush clears, external stall holds, load-use inserts a
    // bubble, otherwise the decode values advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= STAGE_ZERO;
        end else if (flush) begin
            r_stage <= STAGE_ZERO;
        end else if (stall_ext) begin
            r_stage <= r_stage;
        end else if (w_hazard) begin
            r_stage <= STAGE_ZERO;
        end else begin
            r_stage <= w_id_stage;
        end
    end

    // Bubble counter: counts only inserted load-use bubbles, saturating at
    // all-ones; flush leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= CNT_ZERO;
        end else if (w_bubble_ins && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg. Expected stage contents are pushed
// to a scoreboard queue when stimulus is driven and popped after the edge.
// Expectations follow ID_EX_HAZARD_DETECT_EN when it is defined for the build.
module tb_id_ex_stage_reg;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic        valid;
    } stage_t;

    typedef struct packed {
        stage_t     st;
        logic [3:0] cnt;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   stall_ext = 1'b0;
    logic   flush = 1'b0;
    stage_t id_s = '0;

    logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_valid;
    logic [3:0]  o_alu_op;
    logic        hazard_stall;
    logic [3:0]  bubble_cnt;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pc_ID(id_s.pc), .readData1_ID(id_s.rd1), .readData2_ID(id_s.rd2), .imm_ID(id_s.imm),
        .rs1_ID(id_s.rs1), .rs2_ID(id_s.rs2), .rd_ID(id_s.rd),
        .regWrite_ID(id_s.reg_write), .memRead_ID(id_s.mem_read), .memWrite_ID(id_s.mem_write),
        .memToReg_ID(id_s.mem_to_reg), .aluSrc_ID(id_s.alu_src), .aluOp_ID(id_s.alu_op),
        .valid_ID(id_s.valid), .stall_ext(stall_ext), .flush(flush),
        .pc_IDEX(o_pc), .readData1_IDEX(o_rd1), .readData2_IDEX(o_rd2), .imm_IDEX(o_imm),
        .rs1_IDEX(o_rs1), .rs2_IDEX(o_rs2), .rd_IDEX(o_rd),
        .regWrite_IDEX(o_reg_write), .memRead_IDEX(o_mem_read), .memWrite_IDEX(o_mem_write),
        .memToReg_IDEX(o_mem_to_reg), .aluSrc_IDEX(o_alu_src), .aluOp_IDEX(o_alu_op),
        .valid_IDEX(o_valid), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    function automatic exp_t observe();
        exp_t g;
        g.st = {o_pc, o_rd1, o_rd2, o_imm, o_rs1, o_rs2, o_rd, o_reg_write, o_mem_read,
                o_mem_write, o_mem_to_reg, o_alu_src, o_alu_op, o_valid};
        g.cnt = bubble_cnt;
        return g;
    endfunction

    function automatic stage_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic mem_read);
        stage_t s;
        s.pc = pc;
        s.rd1 = pc ^ 32'h1111_0000;
        s.rd2 = pc ^ 32'h0000_2222;
        s.imm = pc + 32'h0000_0010;
        s.rs1 = rs1;
        s.rs2 = rs2;
        s.rd = rd;
        s.reg_write = 1'b1;
        s.mem_read = mem_read;
        s.mem_write = 1'b0;
        s.mem_to_reg = mem_read;
        s.alu_src = mem_read;
        s.alu_op = 4'b0010;
        s.valid = 1'b1;
        return s;
    endfunction

    // Drive ID inputs and control just after an edge, let the comb path settle.
    task automatic drive(input stage_t s, input logic st, input logic fl);
        id_s = s;
        stall_ext = st;
        flush = fl;
        #1;
    endtask

    // Record the expected post-edge state, then advance past the next edge.
    task automatic push_tick(input stage_t s);
        exp_t e;
        e.st = s;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A load-use bubble is expected on this edge (only when detection exists).
    task automatic bump_cnt();
        if (HZ && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        stage_t a, b;
        exp_t g, e;
        a = mk(32'hA000_0004, 5'd1, 5'd2, 5'd7, 1'b1);
        a.mem_write = 1'b1;
        b = mk(32'hB000_0008, 5'd3, 5'd4, 5'd9, 1'b1);
        b.mem_write = 1'b1;
        drive(a, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        g = observe(); checks++;
        if (g !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", g); end
        rst = 1'b0;
        push_tick(a);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL reset_release_capture got=%h exp=%h", g, e); end
        drive(b, 1'b1, 1'b0);
        push_tick(a);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL stall_hold got=%h exp=%h", g, e); end
        #2; rst = 1'b1; #1;
        g = observe(); checks++;
        if (g !== '0) begin failures++; $display("FAIL async_reset_clear got=%h exp=0", g); end
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_hstall got=%b exp=0", hazard_stall); end
        rst = 1'b0;
        stall_ext = 1'b0;
        push_tick(b);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL post_reset_load got=%h exp=%h", g, e); end
    endtask

    task automatic test_load_use();
        stage_t l, d;
        exp_t g, e;
        l = mk(32'h0000_0100, 5'd1, 5'd2, 5'd5, 1'b1);
        d = mk(32'h0000_0104, 5'd5, 5'd6, 5'd8, 1'b0);
        drive(l, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_pre_hstall got=%b exp=0", hazard_stall); end
        push_tick(l);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL lu_load_enter got=%h exp=%h", g, e); end
        drive(d, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== HZ) begin failures++; $display("FAIL lu_hstall got=%b exp=%b", hazard_stall, HZ); end
        bump_cnt();
        push_tick(HZ ? stage_t'('0) : d);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", g, e); end
        drive(d, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_post_hstall got=%b exp=0", hazard_stall); end
        push_tick(d);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL lu_dependent_enter got=%h exp=%h", g, e); end
    endtask

    task automatic test_no_false_stall();
        stage_t l0, x, y;
        exp_t g, e;
        l0 = mk(32'h0000_0200, 5'd1, 5'd3, 5'd0, 1'b1);
        x  = mk(32'h0000_0204, 5'd4, 5'd0, 5'd5, 1'b0);
        y  = mk(32'h0000_0208, 5'd5, 5'd7, 5'd9, 1'b0);
        drive(l0, 1'b0, 1'b0);
        push_tick(l0);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL nfs_rd0_load got=%h exp=%h", g, e); end
        drive(x, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL nfs_rd0_hstall got=%b exp=0", hazard_stall); end
        push_tick(x);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL nfs_rd0_capture got=%h exp=%h", g, e); end
        drive(y, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL nfs_nonload_hstall got=%b exp=0", hazard_stall); end
        push_tick(y);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL nfs_nonload_capture got=%h exp=%h", g, e); end
    endtask

    task automatic test_priority();
        stage_t l, d;
        exp_t g, e;
        l = mk(32'h0000_0300, 5'd1, 5'd2, 5'd5, 1'b1);
        d = mk(32'h0000_0304, 5'd5, 5'd6, 5'd8, 1'b0);
        drive(l, 1'b0, 1'b0);
        push_tick(l);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL pri_load_enter got=%h exp=%h", g, e); end
        drive(d, 1'b1, 1'b1);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("FAIL pri_flush_hstall got=%b exp=0", hazard_stall); end
        push_tick(stage_t'('0));
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL pri_flush_wins got=%h exp=%h", g, e); end
        drive(l, 1'b0, 1'b0);
        push_tick(l);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL pri_reload got=%h exp=%h", g, e); end
        for (int k = 0; k < 2; k++) begin
            drive(d, 1'b1, 1'b0);
            checks++;
            if (hazard_stall !== HZ) begin failures++; $display("FAIL pri_stall_hstall[%0d] got=%b exp=%b", k, hazard_stall, HZ); end
            push_tick(l);
            g = observe(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL pri_stall_hold[%0d] got=%h exp=%h", k, g, e); end
        end
        drive(d, 1'b0, 1'b0);
        checks++;
        if (hazard_stall !== HZ) begin failures++; $display("FAIL pri_release_hstall got=%b exp=%b", hazard_stall, HZ); end
        bump_cnt();
        push_tick(HZ ? stage_t'('0) : d);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL pri_release_bubble got=%h exp=%h", g, e); end
        drive(d, 1'b0, 1'b0);
        push_tick(d);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL pri_dependent_enter got=%h exp=%h", g, e); end
    endtask

    task automatic test_saturation();
        stage_t l, d;
        exp_t g, e;
        for (int i = 0; i < 17; i++) begin
            l = mk(32'h0000_0400 + 32'(i) * 32'd8, 5'd1, 5'd2, 5'd5, 1'b1);
            d = mk(32'h0000_0404 + 32'(i) * 32'd8, (i % 2 == 1) ? 5'd6 : 5'd5,
                   (i % 2 == 1) ? 5'd5 : 5'd6, 5'd8, 1'b0);
            drive(l, 1'b0, 1'b0);
            push_tick(l);
            g = observe(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL sat_load[%0d] got=%h exp=%h", i, g, e); end
            drive(d, 1'b0, 1'b0);
            checks++;
            if (hazard_stall !== HZ) begin failures++; $display("FAIL sat_hstall[%0d] got=%b exp=%b", i, hazard_stall, HZ); end
            bump_cnt();
            push_tick(HZ ? stage_t'('0) : d);
            g = observe(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL sat_bubble[%0d] got=%h exp=%h", i, g, e); end
        end
        checks++;
        if (bubble_cnt !== (HZ ? 4'hF : 4'h0)) begin
            failures++; $display("FAIL sat_final got=%0d exp=%0d", bubble_cnt, HZ ? 15 : 0);
        end
        drive(d, 1'b0, 1'b0);
        push_tick(d);
        g = observe(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL sat_stays got=%h exp=%h", g, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_priority();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
